piezo_tone_decoder: RTL and testbench
=====================================

// Module: piezo_tone_decoder
// PURPOSE
// - Listens to a piezo drive waveform (the sound unit's output, or an external probe pin) and measures its period and high time.
// - Classifies the waveform as a known note, horn or click code once the tone is stable.
// - Sits on the car-simulator debug path: feeds the 7-seg/LCD "now playing" display and self-check logic.
// PARAMETERS
// - CNT_W       21         width of period/high counters (max 2^21-1 cycles)
// - MIN_PERIOD  1000       shortest accepted period in clk cycles; shorter = glitch
// - MAX_PERIOD  1_100_000  silence timeout in cycles (> 50 Hz engine period of 1_000_001)
// - TOL         64         +/- cycle tolerance for stability check and code match
// - CONFIRM     3          consecutive in-tolerance periods required before tone_valid
// PORTS
// - clk          in   1      50 MHz system clock
// - rst_n        in   1      reset, asynchronous, active-low
// - tone_in      in   1      asynchronous piezo waveform
// - period_out   out  CNT_W  last accepted period, clk cycles
// - high_out     out  CNT_W  high cycles within that period
// - tone_valid   out  1      stable tone present
// - tone_code    out  4      classification, see pkg; 0 = none
// - code_change  out  1      1-cycle pulse when tone_code changes while tone_valid = 1
// - silent       out  1      no rising edge for MAX_PERIOD cycles
// BEHAVIOUR
// Reset and input synchronisation
// - Reset (async assert, sync deassert internally): all outputs 0, except silent = 1. State = IDLE.
// - tone_in passes through a 2-flop synchroniser.
// - A rising edge (rise) is sync_q = 1 and prev = 0, giving 3 cycles of latency from the pin.
// Counters
// - cnt increments every cycle, saturating at MAX_PERIOD. On rise, cnt reloads to 1.
// - hcnt increments while sync_q = 1. On rise, hcnt reloads to 1.
// - Measured period = cycles between consecutive rises. Example: 125_001 for the horn.
// State machine
// - IDLE: waits for the first rise -> ARMED. No measurement is taken on this first edge.
// - ARMED: on rise with MIN_PERIOD <= cnt <= MAX_PERIOD-1, the period is accepted.
//   - Update period_out/high_out 1 cycle after rise.
//   - If |cnt - prev_period| <= TOL, stable = min(stable+1, CONFIRM); else stable = 1.
//   - Drop silent.
//   - When stable reaches CONFIRM -> LOCKED.
// - Rise with cnt < MIN_PERIOD is a glitch:
//   - Discard it; keep period_out; set stable = 0.
//   - tone_valid = 0; tone_code = 0; state -> ARMED.
//   - The cnt reload still happens.
// - LOCKED: tone_valid = 1. tone_code comes from the registered compare of period_out against the pkg table.
//   - First entry whose |period - P_k| <= TOL wins; no match gives CODE_UNK (15).
//   - An out-of-tolerance period: tone_valid = 0, tone_code = 0, stable = 1 -> ARMED.
// - Timeout from any state other than IDLE: cnt reaches MAX_PERIOD.
//   - Next cycle: silent = 1, tone_valid = 0, tone_code = 0, stable = 0 -> IDLE.
//   - period_out and high_out hold their last values.
// - code_change:
//   - Pulses on the cycle tone_code takes a new nonzero value while tone_valid = 1 (includes LOCKED entry).
//   - No pulse on a drop to 0.
// - Simultaneous rise and cnt saturation: the rise wins; the period is rejected as > MAX_PERIOD-1.
// - tone_in held constant (DC high or low) ends in timeout.
// - All arithmetic is unsigned, CNT_W bits. Tolerance uses absolute difference, no wrap.
// STRUCTURE
// - sound_pkg holds:
//   - NOTE_* half-period constants, shared with the sound unit.
//   - Full period P = 2*half+1.
//   - Code enum: E4=1, GS4=2, A4=3, B4=4, C5=5, D5=6, DS5=7, E5=8, C4=9, HORN=10, TICK=11, TOCK=12, UNK=15.
//   - Horn P = 125_001; tick P = 25_001; tock P = 31_251.
// - One sub-module, tone_period_meter: synchroniser, edge detect, cnt/hcnt, accept/glitch/timeout strobes.
// - The top level keeps the FSM, stability logic and classifier.
// TESTING
// - Reset mid-lock: assert rst_n = 0 while LOCKED -> all outputs 0, silent = 1 immediately; first tone after release needs CONFIRM+1 edges.
// - Square wave 125_001-cycle period, 31_251 high -> after 4th rise + 1 cycle: tone_valid = 1, tone_code = 10, high_out = 31_251, one code_change pulse.
// - E5 (75_843) for 4 periods, then A4 (113_637) -> code 8, then tone_valid drops, then code 3 after 3 A4 periods, 2 code_change pulses total.
// - Insert a 10-cycle glitch into a locked 25_001 tone -> tone_valid falls, period_out unchanged, relock after CONFIRM good periods.
// - Stop toggling while locked -> silent = 1 exactly MAX_PERIOD cycles after the last rise (+1); tone_code = 0.
// - Engine tone 600_001 period -> tone_valid = 1, tone_code = 15. Then tone 1_200_001 -> never valid; silent pulses via timeout.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared tone definitions: note half-periods (as used by the sound unit),
// classification codes and decoder FSM states.
package sound_pkg;

  typedef enum logic [3:0] {
    CODE_NONE = 4'd0,
    CODE_E4   = 4'd1,
    CODE_GS4  = 4'd2,
    CODE_A4   = 4'd3,
    CODE_B4   = 4'd4,
    CODE_C5   = 4'd5,
    CODE_D5   = 4'd6,
    CODE_DS5  = 4'd7,
    CODE_E5   = 4'd8,
    CODE_C4   = 4'd9,
    CODE_HORN = 4'd10,
    CODE_TICK = 4'd11,
    CODE_TOCK = 4'd12,
    CODE_UNK  = 4'd15
  } tone_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOCKED
  } dec_state_e;

  // Half-periods in 50 MHz cycles; the driven period is 2*half+1.
  localparam int NOTE_E4   = 75_842;
  localparam int NOTE_GS4  = 60_197;
  localparam int NOTE_A4   = 56_818;
  localparam int NOTE_B4   = 50_620;
  localparam int NOTE_C5   = 47_778;
  localparam int NOTE_D5   = 42_565;
  localparam int NOTE_DS5  = 40_176;
  localparam int NOTE_E5   = 37_921;
  localparam int NOTE_C4   = 95_555;
  localparam int NOTE_HORN = 62_500;
  localparam int NOTE_TICK = 12_500;
  localparam int NOTE_TOCK = 15_625;

  localparam int NUM_CODES = 12;

  function automatic int note_half(input int k);
    case (k)
      1:       return NOTE_E4;
      2:       return NOTE_GS4;
      3:       return NOTE_A4;
      4:       return NOTE_B4;
      5:       return NOTE_C5;
      6:       return NOTE_D5;
      7:       return NOTE_DS5;
      8:       return NOTE_E5;
      9:       return NOTE_C4;
      10:      return NOTE_HORN;
      11:      return NOTE_TICK;
      12:      return NOTE_TOCK;
      default: return 0;
    endcase
  endfunction

  function automatic int full_period(input int half);
    return 2 * half + 1;
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronises the piezo pin, detects rising edges and measures period and
// high time; emits accept/glitch/over-range/saturation strobes.
module tone_period_meter #(
  parameter int CNT_W      = 21,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = 1_100_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] hcnt,
  output logic             rise,
  output logic             accept,
  output logic             glitch,
  output logic             over,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PERIOD);

  logic s1, sync_q, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
    end else begin
      s1     <= tone_in;
      sync_q <= s1;
      prev   <= sync_q;
    end
  end

  assign rise = sync_q & ~prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise)              cnt <= CNT_W'(1);
      else if (cnt != MAXP)  cnt <= cnt + CNT_W'(1);
      if (rise)                      hcnt <= CNT_W'(1);
      else if (sync_q && hcnt != '1) hcnt <= hcnt + CNT_W'(1);
    end
  end

  // A rise landing on the saturation cycle is a period that is too long.
  assign accept = rise && (cnt >= MINP) && (cnt < MAXP);
  assign glitch = rise && (cnt < MINP);
  assign over   = rise && (cnt == MAXP);
  assign sat    = !rise && (cnt == MAXP);

endmodule

// File: rtl/piezo_tone_decoder.sv
// Piezo waveform decoder: period stability tracking, lock FSM and
// classification of the locked period against the note table.
module piezo_tone_decoder
  import sound_pkg::*;
#(
  parameter int CNT_W      = 21,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = 1_100_000,
  parameter int TOL        = 64,
  parameter int CONFIRM    = 3,
  // Table half-periods are divided by this; 1 for the 50 MHz system clock.
  parameter int PERIOD_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             tone_valid,
  output logic [3:0]       tone_code,
  output logic             code_change,
  output logic             silent
);

  localparam int               ST_W = $clog2(CONFIRM + 1);
  localparam logic [ST_W-1:0]  CONF = ST_W'(CONFIRM);
  localparam logic [CNT_W-1:0] TOLV = CNT_W'(TOL);

  // Async assert, synchronous release of the internal reset.
  logic [1:0] rsync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  end

  assign rst_i = rsync[1];

  logic [CNT_W-1:0] cnt, hcnt;
  logic             rise, accept, glitch, over, sat;

  tone_period_meter #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD)
  ) u_meter (
    .clk     (clk),
    .rst_n   (rst_i),
    .tone_in (tone_in),
    .cnt     (cnt),
    .hcnt    (hcnt),
    .rise    (rise),
    .accept  (accept),
    .glitch  (glitch),
    .over    (over),
    .sat     (sat)
  );

  function automatic logic [CNT_W-1:0] absdiff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  dec_state_e      state, state_d;
  logic [ST_W-1:0] stable, stable_d;
  tone_code_e      code_q, code_d, cls;
  logic            in_tol, load, silent_d, change_d;

  // Walk the table backwards so the lowest matching code wins.
  always_comb begin
    cls = CODE_UNK;
    for (int k = NUM_CODES; k >= 1; k--) begin
      if (absdiff(cnt, CNT_W'(full_period(note_half(k) / PERIOD_DIV))) <= TOLV)
        cls = tone_code_e'(4'(k));
    end
  end

  assign in_tol = absdiff(cnt, period_out) <= TOLV;

  always_comb begin
    state_d  = state;
    stable_d = stable;
    code_d   = code_q;
    silent_d = silent;
    load     = 1'b0;
    unique case (state)
      ST_IDLE: if (rise) state_d = ST_ARMED;
      default: begin
        if (accept) begin
          load     = 1'b1;
          silent_d = 1'b0;
          if (!in_tol)           stable_d = ST_W'(1);
          else if (stable < CONF) stable_d = stable + ST_W'(1);
          if (state == ST_LOCKED && !in_tol) begin
            state_d = ST_ARMED;
            code_d  = CODE_NONE;
          end else if (stable_d == CONF) begin
            state_d = ST_LOCKED;
            code_d  = cls;
          end
        end else if (glitch || over) begin
          state_d  = ST_ARMED;
          stable_d = '0;
          code_d   = CODE_NONE;
        end else if (sat) begin
          state_d  = ST_IDLE;
          stable_d = '0;
          code_d   = CODE_NONE;
          silent_d = 1'b1;
        end
      end
    endcase
    change_d = (code_d != code_q) && (code_d != CODE_NONE);
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      stable      <= '0;
      code_q      <= CODE_NONE;
      silent      <= 1'b1;
      code_change <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
    end else begin
      state       <= state_d;
      stable      <= stable_d;
      code_q      <= code_d;
      silent      <= silent_d;
      code_change <= change_d;
      if (load) begin
        period_out <= cnt;
        high_out   <= hcnt;
      end
    end
  end

  assign tone_valid = (state == ST_LOCKED);
  assign tone_code  = code_q;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Self-checking bench for piezo_tone_decoder on a scaled-down timebase
// (table halves divided by 100, short silence timeout).
module tb_piezo_tone_decoder;

  localparam int CNT_W = 21;
  localparam int MINP  = 20;
  localparam int MAXP  = 4000;
  localparam int TOL   = 2;
  localparam int CONF  = 3;
  localparam int DIV   = 100;

  // Expected table periods: 2*(half/100)+1.
  localparam int P_HORN = 1251;   // 62_500
  localparam int P_TICK = 251;    // 12_500
  localparam int P_E5   = 759;    // 37_921
  localparam int P_A4   = 1137;   // 56_818
  localparam int P_ENG  = 2001;   // matches no entry
  localparam int P_LONG = 4501;   // longer than the timeout

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period_out, high_out;
  logic             tone_valid, code_change, silent;
  logic [3:0]       tone_code;

  piezo_tone_decoder #(
    .CNT_W(CNT_W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
    .TOL(TOL), .CONFIRM(CONF), .PERIOD_DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in),
    .period_out(period_out), .high_out(high_out),
    .tone_valid(tone_valid), .tone_code(tone_code),
    .code_change(code_change), .silent(silent)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every code_change pulse consumes one expected code.
  always @(negedge clk) begin
    if (rst_n && code_change) begin
      pulses++;
      if (expq.size() == 0) chk("cc_unexpected", {28'd0, tone_code}, 32'd0);
      else begin
        chk("cc_code", {28'd0, tone_code}, expq.pop_front());
        chk("cc_valid", {31'd0, tone_valid}, 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic period(input int p, input int h, input int n);
    repeat (n) begin
      tone_in = 1'b1;
      tick(h);
      tone_in = 1'b0;
      tick(p - h);
    end
  endtask

  // Drives the locking rise and checks valid appears exactly 3 cycles later.
  task automatic lock_probe(input int p, input int h, input int code);
    tone_in = 1'b1;
    tick(2);
    @(negedge clk);
    chk("lock_early", {31'd0, tone_valid}, 32'd0);
    tick(1);
    @(negedge clk);
    chk("lock_valid", {31'd0, tone_valid}, 32'd1);
    chk("lock_code", {28'd0, tone_code}, code);
    tick(h - 3);
    tone_in = 1'b0;
    tick(p - h);
  endtask

  task automatic st(input string tag, input int v, input int c);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, tone_valid}, v);
    chk({tag, "_code"}, {28'd0, tone_code}, c);
  endtask

  initial begin
    #25;
    chk("rst_silent", {31'd0, silent}, 32'd1);
    chk("rst_valid", {31'd0, tone_valid}, 32'd0);
    chk("rst_period", period_out, 32'd0);
    chk("rst_code", {28'd0, tone_code}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(5);

    // Horn: lock on the 4th rise.
    expq.push_back(10);
    period(P_HORN, 313, 3);
    st("horn_pre", 0, 0);
    lock_probe(P_HORN, 313, 10);
    chk("horn_period", period_out, P_HORN);
    chk("horn_high", high_out, 313);
    chk("horn_pulses", pulses, 1);

    // Reset while locked, then relock needs CONFIRM+1 rises.
    tone_in = 1'b1;
    tick(100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, tone_valid}, 32'd0);
    chk("mid_rst_code", {28'd0, tone_code}, 32'd0);
    chk("mid_rst_silent", {31'd0, silent}, 32'd1);
    chk("mid_rst_period", period_out, 32'd0);
    chk("mid_rst_high", high_out, 32'd0);
    tone_in = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    expq.push_back(10);
    period(P_HORN, 313, 3);
    st("relock_pre", 0, 0);
    lock_probe(P_HORN, 313, 10);
    tick(MAXP + 20);
    st("quiet1", 0, 0);
    chk("quiet1_silent", {31'd0, silent}, 32'd1);

    // E5 then A4.
    expq.push_back(8);
    expq.push_back(3);
    period(P_E5, 379, 2);
    @(negedge clk);
    chk("e5_silent_drop", {31'd0, silent}, 32'd0);
    period(P_E5, 379, 2);
    st("e5_lock", 1, 8);
    period(P_A4, 568, 1);
    st("a4_first", 1, 8);
    period(P_A4, 568, 1);
    st("a4_drop", 0, 0);
    chk("a4_period", period_out, P_A4);
    period(P_A4, 568, 2);
    st("a4_lock", 1, 3);
    chk("e5a4_pulses", pulses, 4);
    tick(MAXP + 20);

    // Tick with an inserted glitch.
    expq.push_back(11);
    expq.push_back(11);
    period(P_TICK, 125, 4);
    st("tick_lock", 1, 11);
    period(10, 5, 1);
    period(P_TICK, 125, 1);
    st("glitch", 0, 0);
    chk("glitch_period", period_out, P_TICK);
    period(P_TICK, 125, 2);
    st("glitch_wait", 0, 0);
    period(P_TICK, 125, 1);
    st("relock", 1, 11);

    // Stop toggling (held high): silent exactly MAXP+1 after the rise.
    tone_in = 1'b1;
    tick(MAXP + 2);
    @(negedge clk);
    chk("sil_early", {31'd0, silent}, 32'd0);
    chk("sil_early_valid", {31'd0, tone_valid}, 32'd1);
    tick(1);
    @(negedge clk);
    chk("sil_set", {31'd0, silent}, 32'd1);
    st("sil", 0, 0);
    chk("sil_period", period_out, P_TICK);
    chk("sil_high", high_out, 125);
    tone_in = 1'b0;
    tick(10);

    // Engine tone: unknown code; then an over-long tone never validates.
    expq.push_back(15);
    period(P_ENG, 1000, 4);
    st("eng_lock", 1, 15);
    for (int i = 0; i < 3; i++) begin
      period(P_LONG, 2250, 1);
      st("long", 0, 0);
      chk("long_silent", {31'd0, silent}, 32'd1);
    end

    tick(5);
    chk("sb_empty", expq.size(), 0);
    chk("pulse_total", pulses, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
